// File: rtl/collision_pkg.sv
// Shared types and default geometry for the pairwise collision scheduler.
package collision_pkg;

    localparam int DEF_NUM_BALLS  = 8;
    localparam int DEF_IDX_W      = 3;
    localparam int DEF_X_W        = 9;
    localparam int DEF_Y_W        = 8;
    localparam int DEF_BALL_WIDTH = 19;
    localparam int DEF_CNT_W      = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CMP  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/collision_scheduler_if.sv
// Position read port plus hit stream between the scheduler (master) and its RAM/consumer (slave).
interface collision_scheduler_if
    import collision_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W
);
    logic [IDX_W-1:0] rd_idx_a;
    logic [IDX_W-1:0] rd_idx_b;
    logic [X_W-1:0]   rd_x_a;
    logic [Y_W-1:0]   rd_y_a;
    logic [X_W-1:0]   rd_x_b;
    logic [Y_W-1:0]   rd_y_b;

    // hit stream: a pair transfers on any rising edge with hit_valid && hit_ready;
    // once raised, hit_valid and the indices hold until that transfer (or abort/reset).
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_idx_a;
    logic [IDX_W-1:0] hit_idx_b;

    modport master (
        output rd_idx_a, rd_idx_b, hit_valid, hit_idx_a, hit_idx_b,
        input  rd_x_a, rd_y_a, rd_x_b, rd_y_b, hit_ready
    );

    modport slave (
        input  rd_idx_a, rd_idx_b, hit_valid, hit_idx_a, hit_idx_b,
        output rd_x_a, rd_y_a, rd_x_b, rd_y_b, hit_ready
    );

endinterface

// File: rtl/collision_pair_check.sv
// Combinational overlap test for one ball pair: inclusive per-axis absolute distance bound.
module collision_pair_check
    import collision_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int BALL_WIDTH = DEF_BALL_WIDTH
) (
    input  logic [X_W-1:0] xa,
    input  logic [Y_W-1:0] ya,
    input  logic [X_W-1:0] xb,
    input  logic [Y_W-1:0] yb,
    output logic           hit
);

    logic [X_W:0] dx;
    logic [X_W:0] adx;
    logic [Y_W:0] dy;
    logic [Y_W:0] ady;

    // One extra bit keeps the difference exact, so the magnitude fits unsigned in X_W+1 bits.
    always_comb begin
        dx  = {1'b0, xb} - {1'b0, xa};
        dy  = {1'b0, yb} - {1'b0, ya};
        adx = dx[X_W] ? (~dx + (X_W+1)'(1)) : dx;
        ady = dy[Y_W] ? (~dy + (Y_W+1)'(1)) : dy;
        hit = (adx <= (X_W+1)'(BALL_WIDTH)) && (ady <= (Y_W+1)'(BALL_WIDTH));
    end

endmodule

// File: rtl/collision_scheduler.sv
// Walks every ball pair (i<j) through one shared comparator and streams colliding pairs out.
// Optional feature: define COLLISION_COUNT_EN to add the saturating hit_count output.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_BALLS  = DEF_NUM_BALLS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int BALL_WIDTH = DEF_BALL_WIDTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
`ifdef COLLISION_COUNT_EN
    output logic [CNT_W-1:0]      hit_count,
`endif
    output state_t                state,
    collision_scheduler_if.master bus
);

    if (NUM_BALLS < 2) begin : g_bad_num_balls
        $error("collision_scheduler: NUM_BALLS must be at least 2");
    end

    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, j_q;
    logic             pair_hit;
    logic             last_pair;
    logic             load;
    logic             advance;
    logic             emit;

    collision_pair_check #(
        .X_W        (X_W),
        .Y_W        (Y_W),
        .BALL_WIDTH (BALL_WIDTH)
    ) u_pair_check (
        .xa  (bus.rd_x_a),
        .ya  (bus.rd_y_a),
        .xb  (bus.rd_x_b),
        .yb  (bus.rd_y_b),
        .hit (pair_hit)
    );

    assign last_pair = (i_q == LAST_I) && (j_q == LAST_J);
    assign emit      = (state_q == EMIT);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                load    = 1'b1;
            end
            READ: state_d = CMP;
            CMP: begin
                if (pair_hit) begin
                    state_d = EMIT;
                end else begin
                    advance = !last_pair;
                    state_d = last_pair ? DONE : READ;
                end
            end
            EMIT: if (bus.hit_ready) begin
                advance = !last_pair;
                state_d = last_pair ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort wins over everything, including a handshake in this same cycle
        if (abort) begin
            state_d = IDLE;
            load    = 1'b0;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= IDX_W'(1);
        end else begin
            state_q <= state_d;
            if (load) begin
                i_q <= '0;
                j_q <= IDX_W'(1);
            end else if (advance) begin
                if (j_q == LAST_J) begin
                    i_q <= i_q + IDX_W'(1);
                    j_q <= i_q + IDX_W'(2);
                end else begin
                    j_q <= j_q + IDX_W'(1);
                end
            end
        end
    end

    assign state         = state_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign bus.rd_idx_a  = i_q;
    assign bus.rd_idx_b  = j_q;
    assign bus.hit_valid = emit;
    assign bus.hit_idx_a = emit ? i_q : '0;
    assign bus.hit_idx_b = emit ? j_q : '0;

`ifdef COLLISION_COUNT_EN
    logic             accept;
    logic [CNT_W-1:0] cnt_q;

    assign accept = emit && bus.hit_ready && !abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_count = cnt_q;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: a registered position RAM model and hit scoreboard.
module tb_collision_scheduler;
    import collision_pkg::*;

    logic   clock = 1'b0;
    logic   reset;
    logic   start;
    logic   abort;
    logic   busy;
    logic   done;
    state_t state;
`ifdef COLLISION_COUNT_EN
    logic [4:0] hit_count;
`endif

    collision_scheduler_if #(.IDX_W(3), .X_W(9), .Y_W(8)) bus ();

    collision_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
`ifdef COLLISION_COUNT_EN
        .hit_count (hit_count),
`endif
        .state     (state),
        .bus       (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] px[8];
    logic [7:0] py[8];
    logic [5:0] exp_q[$];
    logic [5:0] got_q[$];

    always #5 clock = ~clock;

    // registered read port: data follows the address by one cycle
    always @(posedge clock) begin
        bus.rd_x_a <= px[bus.rd_idx_a];
        bus.rd_y_a <= py[bus.rd_idx_a];
        bus.rd_x_b <= px[bus.rd_idx_b];
        bus.rd_y_b <= py[bus.rd_idx_b];
    end

    task automatic run_scan(input int stall, input int busy_start, input bit start_in_done,
                            output int cycles);
        int         stall_left;
        bit         held;
        bit         drop_ready;
        logic [2:0] ha, hb;
        got_q.delete();
        cycles     = 0;
        held       = 0;
        drop_ready = 0;
        stall_left = stall;
        ha         = '0;
        hb         = '0;
        @(negedge clock);
        start         = 1'b1;
        bus.hit_ready = (stall == 0);
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            start = 1'b0;
            cycles++;
            if (drop_ready) begin
                bus.hit_ready = (stall == 0);
                drop_ready    = 0;
            end
            if (cycles == busy_start) start = 1'b1;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_in_scan: cycle %0d got %b expected 1", cycles, busy);
            end
            if (bus.hit_valid === 1'b1) begin
                if (held) begin
                    n_checks++;
                    if ({bus.hit_idx_a, bus.hit_idx_b} !== {ha, hb}) begin
                        n_fail++;
                        $display("FAIL hit_hold: got (%0d,%0d) expected (%0d,%0d)",
                                 bus.hit_idx_a, bus.hit_idx_b, ha, hb);
                    end
                end else begin
                    held = 1;
                    ha   = bus.hit_idx_a;
                    hb   = bus.hit_idx_b;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    got_q.push_back({ha, hb});
                    bus.hit_ready = 1'b1;
                    drop_ready    = 1;
                    held          = 0;
                    stall_left    = stall;
                end
            end
            if (done === 1'b1) begin
                if (start_in_done) start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_pulse: got done=%b busy=%b expected done=0 busy=0", done, busy);
                end
                return;
            end
        end
        n_fail++;
        $display("FAIL scan_timeout: got no done in 400 cycles expected done");
        cycles = -1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        bus.hit_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, done, bus.hit_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/valid=%b expected 000", {busy, done, bus.hit_valid});
        end
        n_checks++;
        if (bus.rd_idx_a !== 3'd0 || bus.rd_idx_b !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_rd_idx: got (%0d,%0d) expected (0,1)", bus.rd_idx_a, bus.rd_idx_b);
        end
        n_checks++;
        if (bus.hit_idx_a !== 3'd0 || bus.hit_idx_b !== 3'd0 || state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_hit_idx: got (%0d,%0d) state %0d expected (0,0) state 0",
                     bus.hit_idx_a, bus.hit_idx_b, state);
        end
`ifdef COLLISION_COUNT_EN
        n_checks++;
        if (hit_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", hit_count);
        end
`endif
    endtask

    task automatic test_no_hits();
        int cyc;
        for (int k = 0; k < 8; k++) begin
            px[k] = 9'(k * 40);
            py[k] = 8'd100;
        end
        run_scan(0, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL no_hits: got %0d hits expected 0", got_q.size());
        end
        n_checks++;
        if (cyc != 57) begin
            n_fail++;
            $display("FAIL no_hits_latency: got %0d cycles expected 57", cyc);
        end
    endtask

    task automatic test_single_hit();
        int cyc;
        px = '{9'd100, 9'd200, 9'd250, 9'd119, 9'd300, 9'd350, 9'd400, 9'd450};
        py = '{8'd100, 8'd10, 8'd60, 8'd119, 8'd200, 8'd10, 8'd60, 8'd200};
        run_scan(0, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {3'd0, 3'd3}) begin
            n_fail++;
            $display("FAIL single_hit: got %0d hits first %h expected 1 hit 03", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 6'h3f);
        end
        n_checks++;
        if (cyc != 58) begin
            n_fail++;
            $display("FAIL single_hit_latency: got %0d cycles expected 58", cyc);
        end
        px[3] = 9'd120;
        py[3] = 8'd100;
        run_scan(0, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL dx20_no_hit: got %0d hits expected 0", got_q.size());
        end
    endtask

    task automatic test_negative_delta();
        int cyc;
        px = '{9'd100, 9'd150, 9'd200, 9'd250, 9'd300, 9'd10, 9'd0, 9'd400};
        py = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd50, 8'd31, 8'd200};
        run_scan(0, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {3'd5, 3'd6}) begin
            n_fail++;
            $display("FAIL negative_delta: got %0d hits first %h expected 1 hit 2e", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 6'h3f);
        end
    endtask

    task automatic load_triple();
        px = '{9'd0, 9'd200, 9'd210, 9'd300, 9'd205, 9'd400, 9'd450, 9'd500};
        py = '{8'd0, 8'd100, 8'd110, 8'd200, 8'd95, 8'd20, 8'd200, 8'd240};
        exp_q.delete();
        exp_q.push_back({3'd1, 3'd2});
        exp_q.push_back({3'd1, 3'd4});
        exp_q.push_back({3'd2, 3'd4});
    endtask

    task automatic test_back_pressure();
        int cyc;
        load_triple();
        run_scan(5, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_hit_count: got %0d hits expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL stall_hit_order: slot %0d got %h expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (cyc != 75) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d cycles expected 75", cyc);
        end
`ifdef COLLISION_COUNT_EN
        n_checks++;
        if (hit_count !== 5'd3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected 3", hit_count);
        end
`endif
    endtask

    task automatic test_abort();
        int cyc;
        bit seen;
        bit seen_done;
        load_triple();
        bus.hit_ready = 1'b1;
        @(negedge clock);
        start = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            seen = 0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(negedge clock);
                start = 1'b0;
                seen  = (bus.hit_valid === 1'b1);
            end
            n_checks++;
            if (!seen || {bus.hit_idx_a, bus.hit_idx_b} !== exp_q[pass]) begin
                n_fail++;
                $display("FAIL abort_hit_%0d: got seen=%b (%0d,%0d) expected %h", pass, seen,
                         bus.hit_idx_a, bus.hit_idx_b, exp_q[pass]);
            end
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_checks++;
        if (state !== IDLE || {busy, done, bus.hit_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle: got state %0d busy/done/valid=%b expected state 0 000",
                     state, {busy, done, bus.hit_valid});
        end
`ifdef COLLISION_COUNT_EN
        n_checks++;
        if (hit_count !== 5'd1) begin
            n_fail++;
            $display("FAIL abort_count_hold: got %0d expected 1", hit_count);
        end
`endif
        seen_done = 0;
        repeat (60) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_quiet: got done/busy activity expected none");
        end
        run_scan(0, 0, 0, cyc);
        n_checks++;
        if (got_q.size() != 3 || got_q[0] !== exp_q[0] || got_q[2] !== exp_q[2] || cyc != 60) begin
            n_fail++;
            $display("FAIL abort_rescan: got %0d hits %0d cycles expected 3 hits 60 cycles",
                     got_q.size(), cyc);
        end
`ifdef COLLISION_COUNT_EN
        n_checks++;
        if (hit_count !== 5'd3) begin
            n_fail++;
            $display("FAIL rescan_count: got %0d expected 3", hit_count);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        load_triple();
        bus.hit_ready = 1'b1;
        @(negedge clock);
        start = 1'b1;
        repeat (5) begin
            @(negedge clock);
            start = 1'b0;
        end
        n_checks++;
        if (state !== READ || bus.rd_idx_a !== 3'd0 || bus.rd_idx_b !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_read: got state %0d rd (%0d,%0d) expected state 1 rd (0,3)",
                     state, bus.rd_idx_a, bus.rd_idx_b);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== IDLE || {busy, done, bus.hit_valid} !== 3'b000 ||
            bus.rd_idx_a !== 3'd0 || bus.rd_idx_b !== 3'd1) begin
            n_fail++;
            $display("FAIL async_reset: got state %0d flags %b rd (%0d,%0d) expected 0 000 (0,1)",
                     state, {busy, done, bus.hit_valid}, bus.rd_idx_a, bus.rd_idx_b);
        end
        @(negedge clock);
        reset = 1'b0;
        run_scan(0, 10, 1, cyc);
        n_checks++;
        if (got_q.size() != 3 || got_q[1] !== exp_q[1] || cyc != 60) begin
            n_fail++;
            $display("FAIL scan_after_reset: got %0d hits %0d cycles expected 3 hits 60 cycles",
                     got_q.size(), cyc);
        end
        @(negedge clock);
        n_checks++;
        if (state !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: got state %0d busy %b expected state 0 busy 0", state, busy);
        end
    endtask

    initial begin
        test_reset();
        test_no_hits();
        test_single_hit();
        test_negative_delta();
        test_back_pressure();
        test_abort();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
